uart_tx_fifo: RTL

//  Parametrised UART transmitter with a built-in TX FIFO. Replaces the single-byte uart_tx in the peripheral bus.

---
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO. A word sent into an idle, empty FIFO puts its start bit on tx one clk_en tick later.
// Back-to-back frames are sent with no gap. A send while full is dropped and pulses overflow.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clk_en,
  input  logic                                 send,
  input  logic [DATA_BITS-1:0]                 dout,
  output logic                                 tx,
  output logic                                 busy,
  output logic                                 full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
  output logic                                 overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;
  logic                   push, pop;
  logic [DATA_BITS-1:0]   head;

  // full is judged before any pop in the same cycle
  assign push = send && (count_q != DEPTH_C);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            shreg_d = head;
            par_d   = (PARITY == 1) ? ~^head : ^head;
            tx_d    = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          tx_d    = shreg_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
        S_DATA: begin
          if (bit_q == LAST_BIT) begin
            stop_d = 1'b0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            bit_d   = bit_q + BW'(1);
          end
        end
        S_PAR: begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (stop_q == LAST_STOP) begin
            // next word chains straight into its start bit
            if (count_q != '0) begin
              pop     = 1'b1;
              shreg_d = head;
              par_d   = (PARITY == 1) ? ~^head : ^head;
              tx_d    = 1'b0;
              state_d = S_START;
            end else begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
    ovf_d  = send && (count_q == DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dout;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
